drygascon128_host_seq: RTL and testbench
========================================

Name: drygascon128_host_seq

Overview:
- Command sequencer that acts as the master of the drygascon128 F/G core's 32-bit register interface.
- Takes high-level commands (load C, load X, run F, run G, read C) and streams data in and out over valid/ready.
- Generates the core's wr_*, start and rd_* strobes, and waits on core idle.
- Sits between the system data path and the core. The core's clk_en is tied high outside this block.

Parameters:
IDLE_TIMEOUT, 64, max cycles in WAIT before the op is aborted (range 2..255).

Ports:
clk  in  1  clock
rst  in  1  reset; also drives core_rst
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 LOAD_C, 1 LOAD_X, 2 RUN_F, 3 RUN_G, 4 READ_C; 5-7 illegal
cmd_ds  in  4  domain separator for RUN_F
cmd_rounds  in  4  round count for RUN_F/RUN_G, 1..15
s_valid/s_ready/s_data  in/out/in  1/1/32  input word stream
m_valid/m_ready/m_data/m_last  out/in/out/out  1/1/32/1  output word stream
busy  out  1  ~IDLE
err  out  1  one-cycle error pulse
core_rst  out  1  to core rst
core_din  out  32  to core din
core_ds, core_rounds  out  4 each  captured command fields
core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c  out  1 each  core strobes
core_dout  in  32  core dout, registered in the core
core_idle  in  1  core idle

Behaviour:
- Reset (synchronous, active-high) and output reset values:
  - state IDLE; cmd_ready=1; busy=0, err=0.
  - m_valid=0, m_last=0; FIFO and counters cleared.
  - All core strobes 0; core_rst = rst | abort_pulse (combinational).
  - A reset mid-op discards all buffered data. No further strobes until a new command.
- Core contract:
  - Each wr_*/rd_* strobe advances the core's word counter.
  - Word 0 is the least significant 32 bits. C = 10 words, X = 4, I = 4, R = 4.
  - core_dout is valid the cycle after the rd strobe.
  - core_idle goes low the cycle after core_start.
- Word count N: LOAD_C/READ_C 10; LOAD_X/RUN_F/RUN_G 4.
- IDLE:
  - On cmd_valid & cmd_ready, capture op, ds, rounds; word counter cleared.
  - Illegal op, or rounds=0 with RUN_F/RUN_G: err=1 next cycle, stay IDLE, no strobes.
  - LOAD_*/RUN_F -> WRITE; RUN_G -> START; READ_C -> READ.
- WRITE:
  - s_ready=1.
  - Each s_valid & s_ready cycle: core_din = s_data, and exactly one of wr_c/wr_x/wr_i is asserted that same cycle (combinational).
  - After word N: LOAD_* -> IDLE; RUN_F -> START.
- START:
  - core_start=1 for exactly one cycle; core_ds/core_rounds hold the captured values from capture until IDLE.
  - -> WAIT; timeout counter cleared.
- WAIT:
  - core_idle=1 -> READ.
  - Counter reaches IDLE_TIMEOUT: err pulse plus one-cycle core_rst (abort), -> IDLE, no output words.
- READ:
  - 2-entry output FIFO.
  - Issue rd_r (RUN_*) or rd_c (READ_C) only when fifo_count + inflight < 2 and fewer than N strobes have been issued.
  - Sustains one word per cycle while m_ready=1.
  - Captured core_dout is pushed into the FIFO one cycle after its strobe.
  - After strobe N -> DRAIN.
- DRAIN: when the FIFO is empty and nothing is in flight -> IDLE.
- Output stream:
  - m_data is the FIFO head; m_last=1 on word N-1.
  - m_data/m_last are stable while m_valid & ~m_ready.
  - A simultaneous push and pop keeps the count unchanged.
- Single-cycle ops: cmd_ready rises the cycle after the last write handshake or the last output pop.
- Word counter width is 4 bits; it never exceeds N.

Test Plan:
1. LOAD_C, s_data = 0x0..0x9 back-to-back -> 10 core_wr_c pulses on consecutive cycles, core_din matching, no other strobes, cmd_ready=1 the cycle after the 10th, err=0.
2. RUN_F, ds=5, rounds=7, I = 0xA0..0xA3; core model idle low for 7 cycles, R = 0xB0..0xB3 -> 4 wr_i, one core_start with core_ds=5 and core_rounds=7, then m_data B0..B3 with m_last only on B3.
3. READ_C with m_ready pattern 1,0,1,0 -> 10 words in order, no loss or duplication, never more than 2 rd_c outstanding plus buffered, m_data stable while stalled.
4. RUN_G rounds=11, IDLE_TIMEOUT=16, core_idle stuck 0 -> err and core_rst pulse 16 cycles after WAIT entry, back to IDLE, m_valid never asserted.
5. cmd_op=7, then RUN_G with rounds=0 -> err pulse each, zero core strobes, cmd_ready=1 throughout.
6. rst asserted during READ after 2 words output -> next cycle m_valid=0, busy=0, core_rst=1 while rst is high; a following READ_C returns all 10 words correctly from word 0.

Source files
------------

// File: rtl/drygascon128_host_seq.sv
// Command sequencer that masters the drygascon128 F/G core register interface:
// loads C/X/I words, starts F/G, waits on idle and streams results out through a 2-entry FIFO.
module drygascon128_host_seq #(
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_ds,
    input  logic [3:0]  cmd_rounds,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        err,
    output logic        core_rst,
    output logic [31:0] core_din,
    output logic [3:0]  core_ds,
    output logic [3:0]  core_rounds,
    output logic        core_wr_i,
    output logic        core_wr_c,
    output logic        core_wr_x,
    output logic        core_start,
    output logic        core_rd_r,
    output logic        core_rd_c,
    input  logic [31:0] core_dout,
    input  logic        core_idle
);

    localparam logic [2:0] OpLoadC = 3'd0;
    localparam logic [2:0] OpLoadX = 3'd1;
    localparam logic [2:0] OpRunF  = 3'd2;
    localparam logic [2:0] OpRunG  = 3'd3;
    localparam logic [2:0] OpReadC = 3'd4;

    typedef enum logic [2:0] {StIdle, StWrite, StStart, StWait, StRead, StDrain} state_e;

    state_e      state_q;
    logic [2:0]  op_q;
    logic [3:0]  ds_q;
    logic [3:0]  rounds_q;
    logic [3:0]  cnt_q;
    logic [7:0]  tmo_q;
    logic [31:0] fifo_data_q [2];
    logic [1:0]  fifo_last_q;
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  fifo_cnt_q;
    logic        infl_q;
    logic        infl_last_q;
    logic        err_q;
    logic        abort_q;

    logic [3:0]  n_words;
    logic        is_run;
    logic        cmd_legal;
    logic        wr_hs;
    logic        pop;
    logic        push;
    logic        rd_issue;
    logic [2:0]  occ;

    always_comb begin
        is_run    = (op_q == OpRunF) || (op_q == OpRunG);
        n_words   = ((op_q == OpLoadC) || (op_q == OpReadC)) ? 4'd10 : 4'd4;
        cmd_legal = (cmd_op <= OpReadC) &&
                    !(((cmd_op == OpRunF) || (cmd_op == OpRunG)) && (cmd_rounds == 4'd0));

        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        s_ready   = (state_q == StWrite);
        wr_hs     = s_valid && s_ready;

        core_din  = s_data;
        core_wr_c = wr_hs && (op_q == OpLoadC);
        core_wr_x = wr_hs && (op_q == OpLoadX);
        core_wr_i = wr_hs && (op_q == OpRunF);
        core_start = (state_q == StStart);

        m_valid = (fifo_cnt_q != 2'd0);
        m_data  = fifo_data_q[rd_ptr_q];
        m_last  = m_valid && fifo_last_q[rd_ptr_q];
        pop     = m_valid && m_ready;
        push    = infl_q;

        // A pop this cycle frees a slot, so it is credited to keep one word per cycle.
        occ      = {1'b0, fifo_cnt_q} + {2'b0, infl_q} - {2'b0, pop};
        rd_issue = (state_q == StRead) && (cnt_q < n_words) && (occ < 3'd2);
        core_rd_r = rd_issue && is_run;
        core_rd_c = rd_issue && !is_run;

        core_ds     = ds_q;
        core_rounds = rounds_q;
        err         = err_q;
        core_rst    = rst || abort_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= 3'd0;
            ds_q           <= 4'd0;
            rounds_q       <= 4'd0;
            cnt_q          <= 4'd0;
            tmo_q          <= 8'd0;
            fifo_data_q[0] <= 32'd0;
            fifo_data_q[1] <= 32'd0;
            fifo_last_q    <= 2'b00;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            infl_q         <= 1'b0;
            infl_last_q    <= 1'b0;
            err_q          <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            infl_q      <= rd_issue;
            infl_last_q <= rd_issue && (cnt_q == n_words - 4'd1);

            // core_dout is registered in the core, so it lands one cycle after the strobe.
            if (push) begin
                fifo_data_q[wr_ptr_q] <= core_dout;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end

            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            op_q     <= cmd_op;
                            ds_q     <= cmd_ds;
                            rounds_q <= cmd_rounds;
                            cnt_q    <= 4'd0;
                            case (cmd_op)
                                OpRunG:  state_q <= StStart;
                                OpReadC: state_q <= StRead;
                                default: state_q <= StWrite;
                            endcase
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (wr_hs) begin
                        if (cnt_q == n_words - 4'd1) begin
                            cnt_q   <= 4'd0;
                            state_q <= (op_q == OpRunF) ? StStart : StIdle;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                StStart: begin
                    tmo_q   <= 8'd0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (core_idle) begin
                        cnt_q   <= 4'd0;
                        state_q <= StRead;
                    end else if (tmo_q == 8'(IDLE_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StRead: begin
                    if (rd_issue) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == n_words - 4'd1) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!infl_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop))) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_drygascon128_host_seq.sv
// Self-checking bench for drygascon128_host_seq with a behavioural core model and
// randomized command sequences checked against a word-level reference.
module tb_drygascon128_host_seq;

    localparam int unsigned TMO = 16;
    localparam logic [2:0] OpLoadC = 3'd0;
    localparam logic [2:0] OpLoadX = 3'd1;
    localparam logic [2:0] OpRunF  = 3'd2;
    localparam logic [2:0] OpRunG  = 3'd3;
    localparam logic [2:0] OpReadC = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_ds, cmd_rounds;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic        busy, err, core_rst;
    logic [31:0] core_din, core_dout;
    logic [3:0]  core_ds, core_rounds;
    logic        core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c;
    logic        core_idle;

    always #5 clk = ~clk;

    drygascon128_host_seq #(.IDLE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ds(cmd_ds), .cmd_rounds(cmd_rounds),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err), .core_rst(core_rst), .core_din(core_din),
        .core_ds(core_ds), .core_rounds(core_rounds),
        .core_wr_i(core_wr_i), .core_wr_c(core_wr_c), .core_wr_x(core_wr_x),
        .core_start(core_start), .core_rd_r(core_rd_r), .core_rd_c(core_rd_c),
        .core_dout(core_dout), .core_idle(core_idle)
    );

    // Behavioural core: word-addressed C/X/I storage, R = r_base + word index.
    logic [31:0] cmem [10];
    logic [31:0] xmem [4];
    logic [31:0] imem [4];
    int          cwc, cwx, cwi, crc, crr, busy_cnt;
    int          idle_delay;
    bit          idle_stuck;
    logic [31:0] r_base;

    always @(posedge clk) begin
        if (core_rst) begin
            cwc <= 0; cwx <= 0; cwi <= 0; crc <= 0; crr <= 0;
            busy_cnt <= 0; core_idle <= 1'b1; core_dout <= 32'd0;
        end else begin
            if (core_wr_c) begin cmem[cwc] <= core_din; cwc <= (cwc == 9) ? 0 : cwc + 1; end
            if (core_wr_x) begin xmem[cwx] <= core_din; cwx <= (cwx + 1) % 4; end
            if (core_wr_i) begin imem[cwi] <= core_din; cwi <= (cwi + 1) % 4; end
            if (core_rd_c) begin core_dout <= cmem[crc]; crc <= (crc == 9) ? 0 : crc + 1; end
            if (core_rd_r) begin core_dout <= r_base + 32'(crr); crr <= (crr + 1) % 4; end
            if (core_start) begin
                core_idle <= 1'b0;
                busy_cnt  <= idle_delay;
            end else if (!core_idle && !idle_stuck) begin
                if (busy_cnt <= 1) core_idle <= 1'b1;
                else busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Passive monitor, sampled on the falling edge.
    int cyc = 0, n_wr_c = 0, n_wr_x = 0, n_wr_i = 0, n_start = 0, n_rd = 0, n_err = 0;
    int n_crst = 0, n_mvalid = 0, n_notready = 0, n_multi = 0, n_stab = 0, n_ovf = 0;
    int issued = 0, popped = 0, err_cyc = 0, crst_cyc = 0, start_cyc = 0;
    logic [3:0]  st_ds = 4'd0, st_rounds = 4'd0;
    logic [32:0] out_q [$];
    int          wrc_cyc [$];
    logic [31:0] wrc_din [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            popped     <= issued;
            prev_stall <= 1'b0;
        end else begin
            if (core_wr_c) begin
                n_wr_c <= n_wr_c + 1;
                wrc_cyc.push_back(cyc);
                wrc_din.push_back(core_din);
            end
            if (core_wr_x) n_wr_x <= n_wr_x + 1;
            if (core_wr_i) n_wr_i <= n_wr_i + 1;
            if (core_start) begin
                n_start <= n_start + 1; start_cyc <= cyc;
                st_ds <= core_ds; st_rounds <= core_rounds;
            end
            if (core_rd_r || core_rd_c) n_rd <= n_rd + 1;
            if (err) begin n_err <= n_err + 1; err_cyc <= cyc; end
            if (core_rst) begin n_crst <= n_crst + 1; crst_cyc <= cyc; end
            if (m_valid) n_mvalid <= n_mvalid + 1;
            if (!cmd_ready) n_notready <= n_notready + 1;
            if (int'(core_wr_c) + int'(core_wr_x) + int'(core_wr_i) + int'(core_start)
                + int'(core_rd_r) + int'(core_rd_c) > 1) n_multi <= n_multi + 1;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                n_stab <= n_stab + 1;
            if (m_valid && m_ready) out_q.push_back({m_last, m_data});
            if ((issued + int'(core_rd_r || core_rd_c)) - (popped + int'(m_valid && m_ready)) > 2)
                n_ovf <= n_ovf + 1;
            issued     <= issued + int'(core_rd_r || core_rd_c);
            popped     <= popped + int'(m_valid && m_ready);
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
        cyc <= cyc + 1;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] stim  [16];
    logic [31:0] exp_c [10];
    logic [31:0] exp_x [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [3:0] ds, input logic [3:0] r);
        int n = 0;
        cmd_op = op; cmd_ds = ds; cmd_rounds = r; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            s_data = stim[i]; s_valid = 1'b1;
            while (!s_ready && w < 200) begin tick(); w++; end
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic recv(input int target, input int mode);
        int n = 0;
        while (out_q.size() < target && n < 400) begin
            case (mode)
                1:       m_ready = (n % 2 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            tick();
            n++;
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_ds = 4'd0; cmd_rounds = 4'd0;
        s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b1;
        idle_delay = 3; idle_stuck = 1'b0; r_base = 32'd0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, busy, err} !== 3'b100) begin
            errors++; $display("FAIL reset_ctrl: ready/busy/err=%b required 100", {cmd_ready, busy, err});
        end
        checks++;
        if ({m_valid, m_last} !== 2'b00) begin
            errors++; $display("FAIL reset_stream: m_valid/m_last=%b required 00", {m_valid, m_last});
        end
        checks++;
        if ({core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c} !== 6'd0) begin
            errors++; $display("FAIL reset_strobes: got %b required 000000",
                {core_wr_i, core_wr_c, core_wr_x, core_start, core_rd_r, core_rd_c});
        end
        checks++;
        if (core_rst !== 1'b1) begin
            errors++; $display("FAIL reset_core_rst: got %b required 1", core_rst);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (core_rst !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: core_rst=%b cmd_ready=%b required 0/1",
                core_rst, cmd_ready);
        end
    endtask

    task automatic test_load_c();
        int b_c = n_wr_c, b_oth = n_wr_x + n_wr_i + n_start + n_rd, b_err = n_err;
        int b_q = wrc_din.size();
        for (int i = 0; i < 10; i++) begin stim[i] = 32'(i); exp_c[i] = 32'(i); end
        send_cmd(OpLoadC, 4'd0, 4'd0);
        push_words(10);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL load_c_ready: cmd_ready=%b required 1", cmd_ready);
        end
        checks++;
        if (n_wr_c - b_c != 10) begin
            errors++; $display("FAIL load_c_count: wr_c=%0d required 10", n_wr_c - b_c);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wrc_din[b_q + i] !== 32'(i) ||
                    (i > 0 && wrc_cyc[b_q + i] - wrc_cyc[b_q + i - 1] != 1)) begin
                    errors++; $display("FAIL load_c_word%0d: din=%h gap=%0d required %h gap 1",
                        i, wrc_din[b_q + i], (i > 0) ? wrc_cyc[b_q + i] - wrc_cyc[b_q + i - 1] : 1, i);
                end
            end
        end
        checks++;
        if (n_wr_x + n_wr_i + n_start + n_rd - b_oth != 0 || n_err != b_err) begin
            errors++; $display("FAIL load_c_other: other strobes=%0d err=%0d required 0/0",
                n_wr_x + n_wr_i + n_start + n_rd - b_oth, n_err - b_err);
        end
    endtask

    task automatic test_run_f();
        int b_i = n_wr_i, b_st = n_start, b_q = out_q.size();
        r_base = 32'hB0; idle_delay = 7;
        for (int i = 0; i < 4; i++) stim[i] = 32'hA0 + 32'(i);
        send_cmd(OpRunF, 4'd5, 4'd7);
        push_words(4);
        recv(b_q + 4, 0);
        checks++;
        if (n_wr_i - b_i != 4 || n_start - b_st != 1) begin
            errors++; $display("FAIL run_f_strobes: wr_i=%0d start=%0d required 4/1",
                n_wr_i - b_i, n_start - b_st);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem[i] !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL run_f_i%0d: got %h required %h", i, imem[i], 32'hA0 + i);
            end
        end
        checks++;
        if (st_ds !== 4'd5 || st_rounds !== 4'd7) begin
            errors++; $display("FAIL run_f_fields: ds=%0d rounds=%0d required 5/7", st_ds, st_rounds);
        end
        checks++;
        if (out_q.size() != b_q + 4) begin
            errors++; $display("FAIL run_f_nout: got %0d required 4", out_q.size() - b_q);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[b_q + i] !== {1'(i == 3), 32'hB0 + 32'(i)}) begin
                    errors++; $display("FAIL run_f_out%0d: got %h required %h", i, out_q[b_q + i],
                        {1'(i == 3), 32'hB0 + 32'(i)});
                end
            end
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL run_f_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_read_c_stall();
        int b_q = out_q.size(), b_ovf = n_ovf, b_stab = n_stab, b_rd = n_rd;
        send_cmd(OpReadC, 4'd0, 4'd0);
        recv(b_q + 10, 1);
        repeat (3) tick();
        checks++;
        if (out_q.size() != b_q + 10 || n_rd - b_rd != 10) begin
            errors++; $display("FAIL read_c_count: out=%0d rd_c=%0d required 10/10",
                out_q.size() - b_q, n_rd - b_rd);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_q[b_q + i] !== {1'(i == 9), exp_c[i]}) begin
                    errors++; $display("FAIL read_c_out%0d: got %h required %h", i, out_q[b_q + i],
                        {1'(i == 9), exp_c[i]});
                end
            end
        end
        checks++;
        if (n_ovf != b_ovf || n_stab != b_stab) begin
            errors++; $display("FAIL read_c_flow: overfill=%0d unstable=%0d required 0/0",
                n_ovf - b_ovf, n_stab - b_stab);
        end
    endtask

    task automatic test_timeout();
        int b_err = n_err, b_crst = n_crst, b_mv = n_mvalid, n = 0;
        idle_stuck = 1'b1;
        send_cmd(OpRunG, 4'd3, 4'd11);
        while (n_err == b_err && n < 100) begin tick(); n++; end
        repeat (3) tick();
        checks++;
        if (n_err - b_err != 1 || n_crst - b_crst != 1) begin
            errors++; $display("FAIL timeout_pulses: err=%0d core_rst=%0d required 1/1",
                n_err - b_err, n_crst - b_crst);
        end
        checks++;
        if (err_cyc - (start_cyc + 1) != TMO || crst_cyc != err_cyc) begin
            errors++; $display("FAIL timeout_time: err after wait=%0d core_rst at %0d required %0d/%0d",
                err_cyc - (start_cyc + 1), crst_cyc, TMO, err_cyc);
        end
        checks++;
        if (n_mvalid != b_mv || st_rounds !== 4'd11 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_state: m_valid cycles=%0d rounds=%0d ready=%b required 0/11/1",
                n_mvalid - b_mv, st_rounds, cmd_ready);
        end
        idle_stuck = 1'b0;
    endtask

    task automatic test_illegal();
        int b_err = n_err, b_nr = n_notready;
        int b_s = n_wr_c + n_wr_x + n_wr_i + n_start + n_rd;
        send_cmd(3'd7, 4'd0, 4'd1);
        repeat (2) tick();
        checks++;
        if (n_err - b_err != 1) begin
            errors++; $display("FAIL illegal_op_err: err cycles=%0d required 1", n_err - b_err);
        end
        send_cmd(OpRunG, 4'd2, 4'd0);
        repeat (2) tick();
        checks++;
        if (n_err - b_err != 2) begin
            errors++; $display("FAIL zero_rounds_err: err cycles=%0d required 2", n_err - b_err);
        end
        checks++;
        if (n_wr_c + n_wr_x + n_wr_i + n_start + n_rd - b_s != 0 || n_notready != b_nr) begin
            errors++; $display("FAIL illegal_quiet: strobes=%0d not-ready cycles=%0d required 0/0",
                n_wr_c + n_wr_x + n_wr_i + n_start + n_rd - b_s, n_notready - b_nr);
        end
    endtask

    task automatic test_reset_mid_read();
        int b_q;
        for (int i = 0; i < 10; i++) begin stim[i] = $urandom; exp_c[i] = stim[i]; end
        send_cmd(OpLoadC, 4'd0, 4'd0);
        push_words(10);
        b_q = out_q.size();
        send_cmd(OpReadC, 4'd0, 4'd0);
        recv(b_q + 2, 0);
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (core_rst !== 1'b1) begin
            errors++; $display("FAIL midrst_core_rst: got %b required 1", core_rst);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin
            errors++; $display("FAIL midrst_state: m_valid=%b busy=%b core_rst=%b required 0/0/1",
                m_valid, busy, core_rst);
        end
        rst = 1'b0; m_ready = 1'b1;
        tick(); tick();
        checks++;
        if (out_q.size() != b_q + 2 || core_rst !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet: words=%0d core_rst=%b required 2/0",
                out_q.size() - b_q, core_rst);
        end
        for (int i = 0; i < 10; i++) begin stim[i] = $urandom; exp_c[i] = stim[i]; end
        send_cmd(OpLoadC, 4'd0, 4'd0);
        push_words(10);
        b_q = out_q.size();
        send_cmd(OpReadC, 4'd0, 4'd0);
        recv(b_q + 10, 0);
        checks++;
        if (out_q.size() != b_q + 10) begin
            errors++; $display("FAIL midrst_reread_n: got %0d required 10", out_q.size() - b_q);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (out_q[b_q + i] !== {1'(i == 9), exp_c[i]}) begin
                    errors++; $display("FAIL midrst_reread%0d: got %h required %h", i,
                        out_q[b_q + i], {1'(i == 9), exp_c[i]});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [2:0]  op = 3'($urandom_range(0, 4));
            logic [3:0]  ds = 4'($urandom);
            logic [3:0]  rn = 4'($urandom_range(1, 15));
            int          b_q = out_q.size(), b_st = n_start, nw;
            logic [31:0] exp_w;
            r_base = $urandom; idle_delay = $urandom_range(1, 10);
            nw = (op == OpReadC) ? 10 : 4;
            case (op)
                OpLoadC: begin
                    for (int i = 0; i < 10; i++) begin stim[i] = $urandom; exp_c[i] = stim[i]; end
                    send_cmd(op, ds, rn); push_words(10);
                    for (int i = 0; i < 10; i++) begin
                        checks++;
                        if (cmem[i] !== exp_c[i]) begin
                            errors++; $display("FAIL rnd%0d_c%0d: got %h required %h", it, i, cmem[i], exp_c[i]);
                        end
                    end
                end
                OpLoadX: begin
                    for (int i = 0; i < 4; i++) begin stim[i] = $urandom; exp_x[i] = stim[i]; end
                    send_cmd(op, ds, rn); push_words(4);
                    for (int i = 0; i < 4; i++) begin
                        checks++;
                        if (xmem[i] !== exp_x[i]) begin
                            errors++; $display("FAIL rnd%0d_x%0d: got %h required %h", it, i, xmem[i], exp_x[i]);
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < 4; i++) stim[i] = $urandom;
                    send_cmd(op, ds, rn);
                    if (op == OpRunF) push_words(4);
                    recv(b_q + nw, 2);
                    if (op != OpReadC) begin
                        checks++;
                        if (n_start - b_st != 1 || st_ds !== ds || st_rounds !== rn) begin
                            errors++; $display("FAIL rnd%0d_start: n=%0d ds=%0d rounds=%0d required 1/%0d/%0d",
                                it, n_start - b_st, st_ds, st_rounds, ds, rn);
                        end
                    end
                    checks++;
                    if (out_q.size() != b_q + nw) begin
                        errors++; $display("FAIL rnd%0d_nout: got %0d required %0d", it, out_q.size() - b_q, nw);
                    end else begin
                        for (int i = 0; i < nw; i++) begin
                            exp_w = (op == OpReadC) ? exp_c[i] : r_base + 32'(i);
                            checks++;
                            if (out_q[b_q + i] !== {1'(i == nw - 1), exp_w}) begin
                                errors++; $display("FAIL rnd%0d_out%0d: got %h required %h", it, i,
                                    out_q[b_q + i], {1'(i == nw - 1), exp_w});
                            end
                        end
                    end
                end
            endcase
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_c();
        test_run_f();
        test_read_c_stall();
        test_timeout();
        test_illegal();
        test_reset_mid_read();
        test_random();
        checks++;
        if (n_multi != 0) begin
            errors++; $display("FAIL single_strobe: multi-strobe cycles=%0d required 0", n_multi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
